// File: rtl/note_scheduler.sv
// note_scheduler: takes chart events, waits each one's frame delay, then claims the
// lowest free sprite slot and strobes spawn with the command and start height.
module note_scheduler #(
  parameter int NSLOTS  = 4,
  parameter int CMD_W   = 4,
  parameter int DELAY_W = 8,
  parameter int Y_W     = 10,
  parameter int Y_INI   = 640
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               chart_valid,
  output logic               chart_ready,
  input  logic [CMD_W-1:0]   chart_cmd,
  input  logic [DELAY_W-1:0] chart_delay,
  input  logic               chart_last,
  input  logic [NSLOTS-1:0]  slot_busy,
  output logic [NSLOTS-1:0]  spawn,
  output logic [CMD_W-1:0]   spawn_cmd,
  output logic [Y_W-1:0]     spawn_y,
  output logic               late,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ALLOC, S_SPAWN, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [DELAY_W-1:0] cnt, cnt_n;
  logic [CMD_W-1:0]   cmd_q, cmd_n;
  logic               last_q, last_n;
  logic [NSLOTS-1:0]  reserved, reserved_n;
  logic [NSLOTS-1:0]  spawn_n;
  logic [CMD_W-1:0]   spawn_cmd_n;
  logic [Y_W-1:0]     spawn_y_n;
  logic               late_n, done_n, ready_n;
  logic [NSLOTS-1:0]  free, grant;
  logic               hs;

  // A slot is free only if it is not on screen and not granted-but-not-yet-busy;
  // grant isolates the lowest set bit of the free mask.
  always_comb begin
    free  = ~slot_busy & ~reserved;
    grant = free & (~free + NSLOTS'(1));
    hs    = chart_valid & chart_ready & enable;
  end

  // Next-state and registered-output logic; the ready register follows the next state
  // so that it is high exactly while sitting in FETCH with the block enabled.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_n       = cmd_q;
    last_n      = last_q;
    spawn_n     = '0;
    spawn_cmd_n = '0;
    spawn_y_n   = '0;
    late_n      = late;
    done_n      = done;
    reserved_n  = reserved & ~slot_busy;
    case (state)
      S_IDLE:  if (enable) state_n = S_FETCH;
      S_FETCH: if (hs) begin
        cmd_n   = chart_cmd;
        last_n  = chart_last;
        cnt_n   = chart_delay;
        state_n = S_WAIT;
      end
      S_WAIT: if (enable) begin
        if (cnt == '0)      state_n = S_ALLOC;
        else if (frame_tick) cnt_n  = cnt - DELAY_W'(1);
      end
      S_ALLOC: if (enable) begin
        if (free != '0) begin
          spawn_n     = grant;
          spawn_cmd_n = cmd_q;
          spawn_y_n   = Y_W'(Y_INI);
          reserved_n  = reserved_n | grant;
          state_n     = S_SPAWN;
        end else if (frame_tick) begin
          late_n = 1'b1;
        end
      end
      // The strobe is already on the outputs during this state; it always completes.
      S_SPAWN: state_n = last_q ? S_DRAIN : S_FETCH;
      S_DRAIN: if (enable && slot_busy == '0 && reserved == '0) begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_DONE:  done_n = 1'b1;
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_FETCH) & enable;
  end

  // State and output registers; synchronous reset drops any pending event or spawn.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cmd_q       <= '0;
      last_q      <= 1'b0;
      reserved    <= '0;
      spawn       <= '0;
      spawn_cmd   <= '0;
      spawn_y     <= '0;
      late        <= 1'b0;
      done        <= 1'b0;
      chart_ready <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cmd_q       <= cmd_n;
      last_q      <= last_n;
      reserved    <= reserved_n;
      spawn       <= spawn_n;
      spawn_cmd   <= spawn_cmd_n;
      spawn_y     <= spawn_y_n;
      late        <= late_n;
      done        <= done_n;
      chart_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios plus a randomized event stream checked
// against a sprite-level model of slot occupancy and frame-delay accounting.
module tb_note_scheduler;
  localparam int NS = 4;

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, frame_tick = 1'b0;
  logic       chart_valid = 1'b0, chart_ready, chart_last = 1'b0;
  logic [3:0] chart_cmd = '0;
  logic [7:0] chart_delay = '0;
  logic [NS-1:0] slot_busy, spawn;
  logic [3:0] spawn_cmd;
  logic [9:0] spawn_y;
  logic       late, done;

  note_scheduler dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .chart_valid(chart_valid), .chart_ready(chart_ready), .chart_cmd(chart_cmd),
    .chart_delay(chart_delay), .chart_last(chart_last), .slot_busy(slot_busy),
    .spawn(spawn), .spawn_cmd(spawn_cmd), .spawn_y(spawn_y), .late(late), .done(done)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  int n_assert = 0, n_fail = 0;

  // Sprite model: a spawned slot goes busy some cycles later and stays busy for a while.
  logic          auto_en = 1'b0, rand_mode = 1'b0, rand_tick = 1'b0;
  logic [NS-1:0] manual_busy = '0, auto_busy = '0, occ, seen = '0, model_grant = '0;
  logic          tick_applied = 1'b0;
  int            pend [NS];
  int            life [NS];

  assign slot_busy = manual_busy | auto_busy;

  // Slot occupancy as the chart sees it: strobed, waiting to appear, or on screen.
  always_comb for (int i = 0; i < NS; i++) occ[i] = (pend[i] != 0) | auto_busy[i] | spawn[i];

  // Sprite lifetime model driving the automatic part of slot_busy.
  always @(posedge CLOCK_25) begin
    if (!auto_en) begin
      auto_busy <= '0;
      for (int i = 0; i < NS; i++) begin pend[i] <= 0; life[i] <= 0; end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (spawn[i]) pend[i] <= rand_mode ? int'($urandom_range(1, 4)) : 4;
        else if (pend[i] != 0) begin
          pend[i] <= pend[i] - 1;
          if (pend[i] == 1) begin
            auto_busy[i] <= 1'b1;
            life[i] <= rand_mode ? int'($urandom_range(3, 12)) : 30;
          end
        end else if (auto_busy[i]) begin
          life[i] <= life[i] - 1;
          if (life[i] <= 1) auto_busy[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [NS-1:0] lowest(input logic [NS-1:0] m);
    for (int i = 0; i < NS; i++) if (m[i]) return NS'(1) << i;
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      if (rand_tick) frame_tick = ($urandom_range(0, 3) == 0);
      model_grant  = lowest(~occ & ~manual_busy);
      tick_applied = frame_tick;
      @(posedge CLOCK_25); #1;
      seen = seen | spawn;
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1; step(1);
    frame_tick = 1'b0; step(1);
  endtask

  task automatic send(input logic [3:0] c, input logic [7:0] d, input logic l, input logic hs_tick);
    int k;
    chart_valid = 1'b1; chart_cmd = c; chart_delay = d; chart_last = l;
    k = 0;
    while (chart_ready !== 1'b1 && k < 50) begin step(1); k++; end
    check("hs_ready", {31'd0, chart_ready}, 32'd1);
    if (!rand_tick) frame_tick = hs_tick;
    step(1);
    if (!rand_tick) frame_tick = 1'b0;
    chart_valid = 1'b0;
  endtask

  task automatic wait_spawn(input int max, output logic [NS-1:0] got);
    for (int k = 0; k < max && spawn == '0; k++) step(1);
    got = spawn;
  endtask

  task automatic wait_done(input int max);
    for (int k = 0; k < max && done !== 1'b1; k++) step(1);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; chart_valid = 1'b0; frame_tick = 1'b0;
    manual_busy = '0; auto_en = 1'b0; rand_mode = 1'b0; rand_tick = 1'b0;
    step(2);
    reset = 1'b0; seen = '0;
  endtask

  initial begin
    logic [NS-1:0] got;
    int ticks;

    // 1: reset values, d=0 latency, delayed second event, drain to done
    do_reset();
    check("rst_spawn", {28'd0, spawn}, 32'd0);
    check("rst_cmd", {28'd0, spawn_cmd}, 32'd0);
    check("rst_y", {22'd0, spawn_y}, 32'd0);
    check("rst_flags", {28'd0, chart_ready, late, done, 1'b0}, 32'd0);
    enable = 1'b1;
    send(4'd1, 8'd0, 1'b0, 1'b0);
    step(1);
    check("t1_alloc_nospawn", {28'd0, spawn}, 32'd0);
    step(1);
    check("t1_spawn0", {28'd0, spawn}, 32'b0001);
    check("t1_cmd0", {28'd0, spawn_cmd}, 32'd1);
    check("t1_y0", {22'd0, spawn_y}, 32'd640);
    manual_busy = 4'b0001;
    send(4'd2, 8'd3, 1'b1, 1'b0);
    seen = '0;
    pulse_tick(); pulse_tick(); pulse_tick();
    check("t1_early", {28'd0, seen}, 32'd0);
    step(1);
    check("t1_spawn1", {28'd0, spawn}, 32'b0010);
    check("t1_cmd1", {28'd0, spawn_cmd}, 32'd2);
    check("t1_y1", {22'd0, spawn_y}, 32'd640);
    manual_busy = 4'b0011;
    step(2);
    check("t1_drain_nodone", {30'd0, done, chart_ready}, 32'd0);
    manual_busy = '0;
    wait_done(5);
    check("t1_done", {31'd0, done}, 32'd1);
    step(3);
    check("t1_done_held", {31'd0, done}, 32'd1);

    // 2: all slots busy -> late on tick, grant once slot 2 frees
    do_reset();
    enable = 1'b1; manual_busy = 4'b1111;
    send(4'd4, 8'd0, 1'b0, 1'b0);
    step(3);
    check("t2_late_before", {31'd0, late}, 32'd0);
    pulse_tick(); pulse_tick();
    check("t2_nospawn", {28'd0, seen}, 32'd0);
    check("t2_late", {31'd0, late}, 32'd1);
    manual_busy = 4'b1011;
    wait_spawn(4, got);
    check("t2_spawn", {28'd0, got}, 32'b0100);
    check("t2_cmd", {28'd0, spawn_cmd}, 32'd4);
    check("t2_late_sticky", {31'd0, late}, 32'd1);

    // 3: pause in WAIT freezes the counter
    do_reset();
    enable = 1'b1;
    send(4'd8, 8'd2, 1'b0, 1'b0);
    enable = 1'b0;
    repeat (5) pulse_tick();
    check("t3_frozen_spawn", {28'd0, seen}, 32'd0);
    check("t3_frozen_ready", {31'd0, chart_ready}, 32'd0);
    enable = 1'b1;
    step(4);
    pulse_tick(); step(2);
    check("t3_one_tick", {28'd0, seen}, 32'd0);
    pulse_tick();
    wait_spawn(3, got);
    check("t3_spawn", {28'd0, got}, 32'b0001);
    check("t3_cmd", {28'd0, spawn_cmd}, 32'd8);

    // 4: back-to-back d=0 events with slow busy rise -> distinct slots
    do_reset();
    enable = 1'b1; auto_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(4'(k + 1), 8'd0, (k == 3), 1'b0);
      wait_spawn(4, got);
      check("t4_slot", {28'd0, got}, 32'd1 << k);
      check("t4_cmd", {28'd0, spawn_cmd}, 32'(k + 1));
    end
    wait_done(80);
    check("t4_done", {31'd0, done}, 32'd1);

    // 5: reset in ALLOC and in SPAWN
    do_reset();
    enable = 1'b1; manual_busy = 4'b1111;
    send(4'd3, 8'd0, 1'b0, 1'b0);
    step(3); pulse_tick();
    check("t5_late_set", {31'd0, late}, 32'd1);
    reset = 1'b1; step(1);
    check("t5_alloc_rst", {26'd0, spawn, chart_ready, late}, 32'd0);
    reset = 1'b0; manual_busy = '0;
    step(1);
    check("t5_idle_fetch", {31'd0, chart_ready}, 32'd1);
    send(4'd5, 8'd0, 1'b0, 1'b0);
    step(2);
    check("t5_in_spawn", {28'd0, spawn}, 32'b0001);
    reset = 1'b1; step(1);
    check("t5_spawn_rst", {25'd0, spawn, chart_ready, late, done}, 32'd0);
    reset = 1'b0;
    send(4'd6, 8'd0, 1'b0, 1'b0);
    step(2);
    check("t5_resv_clear", {28'd0, spawn}, 32'b0001);
    check("t5_cmd", {28'd0, spawn_cmd}, 32'd6);

    // 6: tick in the handshake cycle does not count
    do_reset();
    enable = 1'b1;
    send(4'd9, 8'd1, 1'b0, 1'b1);
    step(5);
    check("t6_hs_tick_ignored", {28'd0, seen}, 32'd0);
    pulse_tick();
    wait_spawn(3, got);
    check("t6_spawn", {28'd0, got}, 32'b0001);

    // 7: random events, random ticks, random sprite lifetimes
    do_reset();
    enable = 1'b1; auto_en = 1'b1; rand_mode = 1'b1; rand_tick = 1'b1;
    for (int e = 0; e < 30; e++) begin
      logic [3:0] c;
      logic [7:0] d;
      c = 4'($urandom_range(1, 15));
      d = 8'($urandom_range(0, 3));
      send(c, d, (e == 29), 1'b0);
      ticks = 0;
      for (int k = 0; k < 300 && spawn == '0; k++) begin
        step(1);
        if (tick_applied) ticks++;
      end
      check("r_slot", {28'd0, spawn}, {28'd0, model_grant});
      check("r_cmd", {28'd0, spawn_cmd}, {28'd0, c});
      check("r_y", {22'd0, spawn_y}, 32'd640);
      check("r_delay_met", {31'd0, ticks >= int'(d)}, 32'd1);
    end
    rand_tick = 1'b0; frame_tick = 1'b0;
    wait_done(200);
    check("r_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
